// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serialiser.
// One start bit, eight data bits LSB first, one stop bit; every bit lasts CLOCKS_PER_BAUD cycles.

module uart_tx #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd10417,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy
);

  localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;
  localparam logic [23:0] BAUD_RELOAD = CLOCKS_PER_BAUD - 24'd1;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  state_t      state;
  logic [2:0]  bit_idx;
  logic [23:0] baud_cnt;
  logic [7:0]  shift;

  logic fifo_nonempty;
  logic baud_done;
  logic push;
  logic pop;
  logic idle_next;

  assign fifo_nonempty = (count != '0);
  assign baud_done     = (baud_cnt == '0);
  // Ready depends only on the registered count, never on tx_valid.
  assign tx_ready      = (count < CNT_W'(FIFO_DEPTH));
  assign push          = tx_valid && tx_ready;

  // A pop happens when the serialiser is free to start a frame: from idle, or at the
  // very end of a stop bit so back-to-back frames have no gap.
  always_comb begin
    pop       = 1'b0;
    idle_next = 1'b0;
    case (state)
      StIdle: begin
        pop       = fifo_nonempty;
        idle_next = !fifo_nonempty;
      end
      StStop: begin
        pop       = baud_done && fifo_nonempty;
        idle_next = baud_done && !fifo_nonempty;
      end
      default: begin
        pop       = 1'b0;
        idle_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  // Storage needs no reset: count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      bit_idx  <= '0;
      baud_cnt <= BAUD_RELOAD;
      shift    <= '0;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_busy <= !idle_next || (count_next != '0);
      case (state)
        StIdle: begin
          baud_cnt <= BAUD_RELOAD;
          tx_out   <= 1'b1;
          if (pop) begin
            shift  <= mem[rd_ptr];
            state  <= StStart;
            tx_out <= 1'b0;
          end
        end
        StStart: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            state    <= StData;
            bit_idx  <= '0;
            tx_out   <= shift[0];
            shift    <= {1'b0, shift[7:1]};
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end
        StData: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
              state  <= StStop;
              tx_out <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_out  <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end
        StStop: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            if (pop) begin
              shift  <= mem[rd_ptr];
              state  <= StStart;
              tx_out <= 1'b0;
            end else begin
              state <= StIdle;
            end
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end
        default: begin
          state  <= StIdle;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit with a 4-entry FIFO.
// Expected serial patterns are written out by hand, first bit on the line leftmost.

module tb_uart_tx;

  localparam int Cpb = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_out;
  logic       tx_busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLOCKS_PER_BAUD(24'd16),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_out  (tx_out),
    .tx_busy (tx_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;  // start, d0..d7, stop; first bit in [9]
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] lb_bytes[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Caller sits on the negedge of the first start-bit sample; returns on the last stop sample.
  task automatic watch_frame(input logic [9:0] seq, input string name);
    for (int b = 0; b < 10; b++) begin
      logic first;
      logic stable;
      logic exp_bit;
      exp_bit = seq[9-b];
      first   = tx_out;
      stable  = 1'b1;
      for (int c = 0; c < Cpb; c++) begin
        if (tx_out !== first) stable = 1'b0;
        if (!(b == 9 && c == Cpb - 1)) @(negedge clk);
      end
      check($sformatf("%s bit%0d {stable,value}", name, b),
            32'({stable, first}), 32'({1'b1, exp_bit}));
    end
  endtask

  // Watches the line for n cycles; it must stay high and end not busy.
  task automatic quiet(input int n, input string name);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_out !== 1'b1) lows++;
    end
    check({name, " low cycles"}, 32'(lows), 32'd0);
    check({name, " busy"}, 32'(tx_busy), 32'd0);
  endtask

  // Bench-side receiver: finds the start bit, samples each bit near its middle.
  task automatic rx_byte(output logic [7:0] b, output logic ok);
    int t;
    t  = 0;
    ok = 1'b0;
    b  = 8'h00;
    while (tx_out !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (tx_out === 1'b0) begin
      repeat (Cpb / 2) @(negedge clk);
      if (tx_out === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (Cpb) @(negedge clk);
          b[i] = tx_out;
        end
        repeat (Cpb) @(negedge clk);
        ok = (tx_out === 1'b1);
      end
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rok;

    vecs[0] = '{data: 8'hA5, seq: 10'b0_10100101_1};
    vecs[1] = '{data: 8'h3C, seq: 10'b0_00111100_1};
    vecs[2] = '{data: 8'h01, seq: 10'b0_10000000_1};
    vecs[3] = '{data: 8'h55, seq: 10'b0_10101010_1};
    lb_bytes[0] = 8'h00;
    lb_bytes[1] = 8'h55;
    lb_bytes[2] = 8'hAA;
    lb_bytes[3] = 8'hFF;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset tx_out", 32'(tx_out), 32'd1);
    check("reset tx_busy", 32'(tx_busy), 32'd0);
    check("reset tx_ready", 32'(tx_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset tx_ready", 32'(tx_ready), 32'd1);

    // Single frames from idle: one-cycle latency, exact bit timing, busy falls after 160.
    foreach (vecs[v]) begin
      tx_valid = 1'b1;
      tx_data  = vecs[v].data;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = ~vecs[v].data;
      check($sformatf("v%0d busy after write", v), 32'(tx_busy), 32'd1);
      check($sformatf("v%0d line still high", v), 32'(tx_out), 32'd1);
      @(negedge clk);
      watch_frame(vecs[v].seq, $sformatf("v%0d", v));
      check($sformatf("v%0d busy at 159", v), 32'(tx_busy), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d busy at 160", v), 32'(tx_busy), 32'd0);
      check($sformatf("v%0d idle line", v), 32'(tx_out), 32'd1);
    end

    // Back-to-back 0x00 then 0xFF: second start exactly 160 cycles after the first.
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(negedge clk);
    tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h5A;
    watch_frame(10'b0_00000000_1, "b2b first");
    @(negedge clk);
    watch_frame(10'b0_11111111_1, "b2b second");
    @(negedge clk);
    check("b2b busy after 320", 32'(tx_busy), 32'd0);

    // Full FIFO: 0x01 in flight, 0x02..0x05 queued, 0x06 refused.
    tx_valid = 1'b1;
    tx_data  = 8'h01;
    fork
      begin
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          tx_data = 8'(k + 1);
          if (k == 4) check("full ready at count 3", 32'(tx_ready), 32'd1);
        end
        check("full ready low", 32'(tx_ready), 32'd0);
        repeat (156) @(negedge clk);
        check("full ready held low", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        @(negedge clk);
        check("ready on first pop", 32'(tx_ready), 32'd1);
      end
      begin
        repeat (2) @(negedge clk);
        watch_frame(10'b0_10000000_1, "full 01");
        @(negedge clk);
        watch_frame(10'b0_01000000_1, "full 02");
        @(negedge clk);
        watch_frame(10'b0_11000000_1, "full 03");
        @(negedge clk);
        watch_frame(10'b0_00100000_1, "full 04");
        @(negedge clk);
        watch_frame(10'b0_10100000_1, "full 05");
        @(negedge clk);
        check("full no 06 frame", 32'(tx_busy), 32'd0);
      end
    join
    quiet(40, "full tail");

    // Loopback through the bench receiver.
    tx_valid = 1'b1;
    tx_data  = lb_bytes[0];
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      tx_data = lb_bytes[i];
    end
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_byte(rb, rok);
      check($sformatf("rx%0d framed", i), 32'(rok), 32'd1);
      check($sformatf("rx%0d data", i), 32'(rb), 32'(lb_bytes[i]));
    end
    quiet(200, "after loopback");

    // Reset during bit 3 of 0x3C with two bytes queued; writes under reset are dropped.
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(negedge clk);
    tx_data = 8'h11;
    @(negedge clk);
    tx_data = 8'h22;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (71) @(negedge clk);
    check("mid bit3 value", 32'(tx_out), 32'd1);
    check("mid busy", 32'(tx_busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid reset tx_out", 32'(tx_out), 32'd1);
    check("mid reset tx_busy", 32'(tx_busy), 32'd0);
    check("mid reset tx_ready", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    repeat (2) @(negedge clk);
    check("write under reset busy", 32'(tx_busy), 32'd0);
    tx_valid = 1'b0;
    reset    = 1'b0;
    quiet(400, "after mid reset");

    // Reset during a start bit must raise the line without waiting for a clock.
    tx_valid = 1'b1;
    tx_data  = 8'h01;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    check("start bit low", 32'(tx_out), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("start reset tx_out", 32'(tx_out), 32'd1);
    check("start reset tx_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    quiet(200, "after start reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BAUD, default 24'd10417, meaning clk cycles per bit (100 MHz / 9600), legal range 2..2^24-1.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of transmit byte entries; it is a power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, and all logic is rising-edge triggered.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port tx_data, input, 8 bits: the byte to transmit.
REQ-006 SHALL have port tx_valid, input, 1 bit: tx_data is offered this cycle.
REQ-007 SHALL have port tx_ready, output, 1 bit: the FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx_out, output, 1 bit, registered: the serial line, idle high.
REQ-009 SHALL have port tx_busy, output, 1 bit, registered: a frame is in progress or the FIFO is non-empty.

Function
REQ-010 SHALL use 8N1 framing: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-011 SHALL hold every bit, including start and stop, on tx_out for exactly CLOCKS_PER_BAUD cycles, so each frame lasts 10*CLOCKS_PER_BAUD cycles.
REQ-012 SHALL accept a byte on a rising edge when tx_valid=1 and tx_ready=1; the byte is written to the FIFO tail.
REQ-013 SHALL drive tx_ready = (FIFO count < FIFO_DEPTH), decoded from registered state with no combinational path from tx_valid.
REQ-014 SHALL ignore tx_valid while tx_ready=0: no write, no overwrite, no error flag.
REQ-015 SHALL use a FIFO count of log2(FIFO_DEPTH)+1 bits; read and write pointers wrap modulo FIFO_DEPTH.
REQ-016 SHALL implement state machine states IDLE, START, DATA (with a 3-bit bit index), and STOP.
REQ-017 In IDLE with count>0, SHALL pop the head entry into the shift register, go to START, and drive tx_out=0 from the next edge.
REQ-018 On a write at edge N into an empty FIFO while in IDLE, SHALL make tx_out low starting at edge N+1 (one-cycle latency).
REQ-019 START SHALL go to DATA index 0 after one baud period; DATA index i SHALL drive shift bit i and advance to i+1, or to STOP after index 7.
REQ-020 At the end of STOP, SHALL go directly to START with a pop if count>0 (back-to-back frames, no idle gap); otherwise SHALL go to IDLE.
REQ-021 SHALL reload the baud counter to CLOCKS_PER_BAUD-1 on every state or bit change and SHALL hold it in IDLE.
REQ-022 SHALL accept a simultaneous push and pop on the same edge, leaving count unchanged and keeping data order intact.
REQ-023 SHALL drive tx_busy=1 whenever state≠IDLE or count>0, updated on the same edge as the state/count change.
REQ-024 Changes to tx_data after acceptance SHALL NOT affect any queued or in-flight frame.

Reset
REQ-025 While reset is asserted, SHALL force asynchronously: state=IDLE, count=0, pointers=0, tx_out=1, tx_busy=0, baud counter=CLOCKS_PER_BAUD-1.
REQ-026 SHALL hold tx_ready=1 during and after reset.
REQ-027 On reset mid-frame, SHALL drive tx_out high immediately, discard the frame and the FIFO contents, and never resume the aborted frame.
REQ-028 SHALL NOT accept a write on an edge where reset is high; normal operation resumes on the first edge after deassertion.

Verification (CLOCKS_PER_BAUD=16, FIFO_DEPTH=4)
REQ-029 Single byte: write 0xA5 -> tx_out low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles; tx_busy falls 160 cycles after the start bit begins.
REQ-030 Back-to-back: write 0x00 then 0xFF on consecutive cycles -> two frames totalling 320 cycles with no idle gap; second start bit begins exactly 160 cycles after the first.
REQ-031 Full FIFO: hold tx_valid=1 with 0x01..0x06 from idle -> 0x01 popped, 0x02..0x05 queued, tx_ready=0, 0x06 not accepted; tx_ready returns to 1 on the first pop (start of frame 0x02).
REQ-032 Mid-frame reset: assert reset during bit 3 of 0x3C with two bytes queued -> tx_out=1 and tx_busy=0 immediately, tx_ready=1; no further frames without new writes.
REQ-033 Loopback: connect tx_out to the team's receiver at the same baud -> bytes 0x00, 0x55, 0xAA, 0xFF are received in order, each with one data_valid pulse.
